// File: rtl/jtpopeye_bck_arb_pkg.sv
// Shared types for the background tile RAM arbiter.
// Holds the arbiter state encoding, the RAM address width and the nibble merge.
package jtpopeye_bck_arb_pkg;

    localparam int AW = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VRD  = 2'd1,
        ST_CRD  = 2'd2,
        ST_CWR  = 2'd3
    } bck_st_e;

    // Replace one nibble of a byte read back from RAM.
    function automatic logic [7:0] nib_merge(
        input logic       hi,
        input logic [3:0] nib,
        input logic [7:0] old
    );
        return hi ? {nib, old[3:0]} : {old[7:4], nib};
    endfunction

endpackage

// File: rtl/jtpopeye_bck_arb_wbuf.sv
// One-entry CPU nibble write buffer: accept handshake, full flag, merge data.
// Ports: cpu_* request in, clr_i (write issued), ram_dout_i in; full/addr/din out.
module jtpopeye_bck_arb_wbuf
    import jtpopeye_bck_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_cen_i,
    input  logic          cpu_we_i,
    input  logic [12:0]   cpu_addr_i,
    input  logic [7:0]    cpu_dd_i,
    input  logic          clr_i,
    input  logic [7:0]    ram_dout_i,
    output logic          full_o,
    output logic [AW-1:0] addr_o,
    output logic [7:0]    din_o
);

    logic          full_q, full_d;
    logic [AW-1:0] addr_q;
    logic          hi_q;
    logic [3:0]    nib_q;
    logic          accept;

    assign accept = cpu_we_i & cpu_cen_i & ~full_q;

    always_comb begin
        full_d = full_q;
        if (clr_i) begin
            full_d = 1'b0;
        end else if (accept) begin
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            addr_q <= '0;
            hi_q   <= 1'b0;
            nib_q  <= 4'd0;
        end else begin
            full_q <= full_d;
            if (accept) begin
                addr_q <= cpu_addr_i[AW-1:0];
                hi_q   <= cpu_addr_i[12];
                nib_q  <= cpu_addr_i[12] ? cpu_dd_i[7:4] : cpu_dd_i[3:0];
            end
        end
    end

    assign full_o = full_q;
    assign addr_o = addr_q;
    // ram_dout holds the byte read in CRD while the FSM sits in CWR.
    assign din_o  = nib_merge(hi_q, nib_q, ram_dout_i);

endmodule

// File: rtl/jtpopeye_bck_arb.sv
// Background tile RAM arbiter: video fetches win, CPU nibble writes use RMW.
// Ports: pixel/video request in, CPU write in, RAM port out, bakc_o colour out.
module jtpopeye_bck_arb
    import jtpopeye_bck_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen_i,
    input  logic          cpu_cen_i,
    input  logic          cpu_we_i,
    input  logic [12:0]   cpu_addr_i,
    input  logic [7:0]    cpu_dd_i,
    output logic          cpu_wait_o,
    input  logic          vid_req_i,
    input  logic [AW-1:0] vid_addr_i,
    input  logic          vid_nib_i,
    output logic [3:0]    bakc_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [7:0]    ram_din_o,
    output logic          ram_we_o,
    input  logic [7:0]    ram_dout_i
);

    bck_st_e       st_q, st_d;
    logic          vpend_q, vpend_d;
    logic [AW-1:0] vaddr_q;
    logic          vnib_q;
    logic          cap_q, capnib_q;
    logic [3:0]    vdat_q, bakc_q;
    logic          vlatch;
    logic          wfull;
    logic [AW-1:0] waddr;
    logic [7:0]    wdin;

    jtpopeye_bck_arb_wbuf u_wbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_cen_i  (cpu_cen_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_dd_i   (cpu_dd_i),
        .clr_i      (st_q == ST_CWR),
        .ram_dout_i (ram_dout_i),
        .full_o     (wfull),
        .addr_o     (waddr),
        .din_o      (wdin)
    );

    assign vlatch = pxl_cen_i & vid_req_i;

    // A request latched this clk counts as pending already, so the fetch
    // starts without an idle clk and lands well before the next pixel.
    always_comb begin
        vpend_d = vpend_q;
        if (vlatch) begin
            vpend_d = 1'b1;
        end else if (st_q == ST_VRD) begin
            vpend_d = 1'b0;
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            ST_CRD: st_d = ST_CWR;
            default: begin
                if (vpend_d) begin
                    st_d = ST_VRD;
                end else if (wfull && st_q != ST_CWR) begin
                    st_d = ST_CRD;
                end else begin
                    st_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        ram_addr_o = '0;
        ram_din_o  = 8'd0;
        ram_we_o   = 1'b0;
        unique case (st_q)
            ST_VRD: ram_addr_o = vaddr_q;
            ST_CRD: ram_addr_o = waddr;
            ST_CWR: begin
                ram_addr_o = waddr;
                ram_din_o  = wdin;
                ram_we_o   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= ST_IDLE;
            vpend_q  <= 1'b0;
            vaddr_q  <= '0;
            vnib_q   <= 1'b0;
            cap_q    <= 1'b0;
            capnib_q <= 1'b0;
            vdat_q   <= 4'd0;
            bakc_q   <= 4'd0;
        end else begin
            st_q     <= st_d;
            vpend_q  <= vpend_d;
            cap_q    <= (st_q == ST_VRD);
            capnib_q <= vnib_q;
            if (vlatch) begin
                vaddr_q <= vid_addr_i;
                vnib_q  <= vid_nib_i;
            end
            if (cap_q) begin
                vdat_q <= capnib_q ? ram_dout_i[3:0] : ram_dout_i[7:4];
            end
            if (pxl_cen_i) begin
                bakc_q <= vdat_q;
            end
        end
    end

    assign bakc_o     = bakc_q;
    assign cpu_wait_o = wfull;

endmodule
